// File: rtl/ycbcr888_rgb888.sv
// YCbCr888 -> RGB888 decoder, full-range BT.601 in 8.8 fixed point.
// Three register stages: products, signed sums, clamp; framing delayed to match.
module ycbcr888_rgb888 #(
   parameter bit ROUND      = 1'b1,
   parameter bit ZERO_BLANK = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       per_frame_vsync,
   input  logic       per_frame_href,
   input  logic       per_frame_clken,
   input  logic [7:0] per_img_Y,
   input  logic [7:0] per_img_Cb,
   input  logic [7:0] per_img_Cr,
   output logic       post_frame_vsync,
   output logic       post_frame_href,
   output logic       post_frame_clken,
   output logic [7:0] post_img_red,
   output logic [7:0] post_img_green,
   output logic [7:0] post_img_blue
);

   localparam int K = ROUND ? 128 : 0;
   // Chroma offset constants folded together with the rounding term.
   localparam logic signed [19:0] C_R = 20'(K - 45952);
   localparam logic signed [19:0] C_G = 20'(K + 34688);
   localparam logic signed [19:0] C_B = 20'(K - 58112);

   logic [18:0] r_y256, r_cr359, r_cb88, r_cr183, r_cb454;
   logic signed [19:0] r_sum_r, r_sum_g, r_sum_b;
   logic [7:0]  r_red, r_green, r_blue;
   logic [2:0]  r_vsync_sr, r_href_sr, r_clken_sr;

   logic signed [19:0] w_sum_r, w_sum_g, w_sum_b;
   logic signed [19:0] w_shr_r, w_shr_g, w_shr_b;

   function automatic logic [7:0] clamp8(input logic signed [19:0] v);
      if (v[19])
         clamp8 = 8'd0;
      else if (|v[18:8])
         clamp8 = 8'd255;
      else
         clamp8 = v[7:0];
   endfunction

   assign w_sum_r = $signed({1'b0, r_y256}) + $signed({1'b0, r_cr359}) + C_R;
   assign w_sum_g = $signed({1'b0, r_y256}) - $signed({1'b0, r_cb88})
                  - $signed({1'b0, r_cr183}) + C_G;
   assign w_sum_b = $signed({1'b0, r_y256}) + $signed({1'b0, r_cb454}) + C_B;

   assign w_shr_r = r_sum_r >>> 8;
   assign w_shr_g = r_sum_g >>> 8;
   assign w_shr_b = r_sum_b >>> 8;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_y256     <= '0;
         r_cr359    <= '0;
         r_cb88     <= '0;
         r_cr183    <= '0;
         r_cb454    <= '0;
         r_sum_r    <= '0;
         r_sum_g    <= '0;
         r_sum_b    <= '0;
         r_red      <= '0;
         r_green    <= '0;
         r_blue     <= '0;
         r_vsync_sr <= '0;
         r_href_sr  <= '0;
         r_clken_sr <= '0;
      end else begin
         r_y256     <= {3'b000, per_img_Y, 8'h00};
         r_cr359    <= 19'(per_img_Cr) * 19'd359;
         r_cb88     <= 19'(per_img_Cb) * 19'd88;
         r_cr183    <= 19'(per_img_Cr) * 19'd183;
         r_cb454    <= 19'(per_img_Cb) * 19'd454;
         r_sum_r    <= w_sum_r;
         r_sum_g    <= w_sum_g;
         r_sum_b    <= w_sum_b;
         r_red      <= clamp8(w_shr_r);
         r_green    <= clamp8(w_shr_g);
         r_blue     <= clamp8(w_shr_b);
         r_vsync_sr <= {r_vsync_sr[1:0], per_frame_vsync};
         r_href_sr  <= {r_href_sr[1:0],  per_frame_href};
         r_clken_sr <= {r_clken_sr[1:0], per_frame_clken};
      end
   end

   assign post_frame_vsync = r_vsync_sr[2];
   assign post_frame_href  = r_href_sr[2];
   assign post_frame_clken = r_clken_sr[2];

   // Blanking acts on the output side so the pipeline itself never stalls.
   assign post_img_red   = (ZERO_BLANK && !r_href_sr[2]) ? 8'd0 : r_red;
   assign post_img_green = (ZERO_BLANK && !r_href_sr[2]) ? 8'd0 : r_green;
   assign post_img_blue  = (ZERO_BLANK && !r_href_sr[2]) ? 8'd0 : r_blue;

endmodule
